// File: rtl/mult_arbiter.sv
// mult_arbiter: two requesters share one shift-add multiplier.
// Ties are broken against the last-served requester; each operation runs exactly W iterations.
module mult_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  input  logic             req1,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             id,
  output logic [2*W-1:0]   p
);

  localparam int unsigned NW = $clog2(W + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StAdd,
    StShift,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [2*W-1:0]  a_q, a_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  p_q, p_d;
  logic [W-1:0]    b_q, b_d;
  logic [NW-1:0]   n_q, n_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  logic            done_q, done_d;
  logic [1:0]      gnt_q, gnt_d;

  logic            sel;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;

  // A lone requester always wins; on a tie the one not served last time wins.
  assign sel   = (req0 && req1) ? ~last_q : req1;
  assign a_sel = sel ? a1 : a0;
  assign b_sel = sel ? b1 : b0;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    n_d     = n_q;
    last_d  = last_q;
    id_d    = id_q;
    p_d     = p_q;
    gnt_d   = 2'b00;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          a_d     = {{W{1'b0}}, a_sel};
          b_d     = b_sel;
          acc_d   = '0;
          n_d     = NW'(W);
          id_d    = sel;
          last_d  = sel;
          gnt_d   = sel ? 2'b10 : 2'b01;
          state_d = StLoad;
        end
      end
      StLoad: state_d = StCheck;
      StCheck: begin
        if (n_q == '0) begin
          p_d     = acc_q;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (b_q[0]) begin
          state_d = StAdd;
        end else begin
          state_d = StShift;
        end
      end
      StAdd: begin
        acc_d   = acc_q + a_q;
        state_d = StShift;
      end
      StShift: begin
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        n_d     = n_q - NW'(1);
        state_d = StCheck;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      p_q     <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      last_q  <= last_d;
      id_q    <= id_d;
      p_q     <= p_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign id   = id_q;
  assign p    = p_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed vectors, corner sequences and a
// randomized two-requester run against a transaction-level model.
module tb_mult_arbiter;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req0 = 1'b0;
  logic           req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]     gnt;
  logic           busy, done, id;
  logic [2*W-1:0] p;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mult_arbiter #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .a0   (a0),
    .b0   (b0),
    .req1 (req1),
    .a1   (a1),
    .b1   (b1),
    .gnt  (gnt),
    .busy (busy),
    .done (done),
    .id   (id),
    .p    (p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm, input string what);
    total++;
    bad++;
    $display("FAIL %s: got %s", nm, what);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input string nm, output int c, output bit ok);
    ok = 1'b0; c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        c = cyc; ok = 1'b1;
        return;
      end
    end
    fail(nm, "no grant within 200 cycles, required a grant");
  endtask

  task automatic wait_done(input string nm, output int c, output bit ok);
    ok = 1'b0; c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        c = cyc; ok = 1'b1;
        return;
      end
    end
    fail(nm, "no done within 200 cycles, required a done pulse");
  endtask

  // Single-requester operation on port 0 with a known product and latency.
  task automatic run_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_p, input int exp_lat);
    int tg, td;
    bit ok;
    @(negedge clk);
    req0 = 1'b1; a0 = a; b0 = b;
    wait_gnt({nm, ".gnt"}, tg, ok);
    if (!ok) return;
    chk({nm, ".gnt"}, gnt, 2'b01);
    req0 = 1'b0;
    wait_done({nm, ".done"}, td, ok);
    if (!ok) return;
    chk({nm, ".p"}, p, exp_p);
    chk({nm, ".id"}, id, 0);
    chk({nm, ".lat"}, td - tg, exp_lat);
    @(negedge clk);
    chk({nm, ".p_hold"}, p, exp_p);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           p;
    int           lat;
  } vec_t;

  function automatic logic [W-1:0] rnd_op();
    int k = $urandom_range(0, 7);
    if (k == 0) return '0;
    if (k == 1) return '1;
    return W'($urandom);
  endfunction

  initial begin
    vec_t tbl[6];
    int   tg, td, dc;
    bit   ok;
    int   ndone;
    logic [W-1:0] ea[2], eb[2];
    bit   r[2], gl[2];
    bit   outst, exp_l, ew;
    int   exp_done, next_free, exp_id;
    logic [2*W-1:0] exp_p;

    tbl[0] = '{a: 8'd3,   b: 8'd5,   p: 15,    lat: 20};
    tbl[1] = '{a: 8'd255, b: 8'd255, p: 65025, lat: 26};
    tbl[2] = '{a: 8'd200, b: 8'd0,   p: 0,     lat: 18};
    tbl[3] = '{a: 8'd0,   b: 8'd255, p: 0,     lat: 26};
    tbl[4] = '{a: 8'd1,   b: 8'd128, p: 128,   lat: 19};
    tbl[5] = '{a: 8'd170, b: 8'd85,  p: 14450, lat: 22};

    // Reset values
    rst = 1'b1;
    #1;
    chk("rst.gnt", gnt, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.id", id, 0);
    chk("rst.p", p, 0);
    @(negedge clk);
    rst = 1'b0;

    // Simultaneous requests right after reset: port 0 first, port 1 at DONE+2
    @(negedge clk);
    req0 = 1'b1; a0 = 8'd2; b0 = 8'd2;
    req1 = 1'b1; a1 = 8'd7; b1 = 8'd9;
    wait_gnt("tie.first", tg, ok);
    chk("tie.first_gnt", gnt, 2'b01);
    req0 = 1'b0;
    wait_done("tie.first_done", dc, ok);
    chk("tie.first_p", p, 4);
    chk("tie.first_id", id, 0);
    wait_gnt("tie.second", tg, ok);
    chk("tie.second_gnt", gnt, 2'b10);
    chk("tie.second_spacing", tg - dc, 2);
    req1 = 1'b0;
    wait_done("tie.second_done", td, ok);
    chk("tie.second_p", p, 63);
    chk("tie.second_id", id, 1);

    for (int i = 0; i < 6; i++) run_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
                                        tbl[i].p, tbl[i].lat);

    // Reset in the middle of an ADD: everything clears at once, no done follows
    @(negedge clk);
    req1 = 1'b1; a1 = 8'd3; b1 = 8'd5;
    wait_gnt("midrst.gnt", tg, ok);
    chk("midrst.gnt", gnt, 2'b10);
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst.gnt0", gnt, 0);
    chk("midrst.busy0", busy, 0);
    chk("midrst.done0", done, 0);
    chk("midrst.id0", id, 0);
    chk("midrst.p0", p, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst.no_done", ndone, 0);
    run_one("post_rst", 8'd6, 8'd7, 42, 21);

    // Both held high continuously: grants alternate 0,1,0,1
    do_reset();
    req0 = 1'b1; a0 = 8'd11;  b0 = 8'd13;
    req1 = 1'b1; a1 = 8'd250; b1 = 8'd3;
    dc = -100;
    for (int k = 0; k < 4; k++) begin
      wait_gnt($sformatf("alt%0d.gnt", k), tg, ok);
      if (!ok) break;
      chk($sformatf("alt%0d.gnt", k), gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) chk($sformatf("alt%0d.spacing", k), tg - dc, 2);
      wait_done($sformatf("alt%0d.done", k), dc, ok);
      if (!ok) break;
      chk($sformatf("alt%0d.p", k), p, (k % 2 == 0) ? 143 : 750);
      chk($sformatf("alt%0d.lat", k), dc - tg, (k % 2 == 0) ? 21 : 20);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Randomized run against a transaction-level model
    do_reset();
    exp_l = 1'b1; outst = 1'b0; next_free = cyc + 1;
    exp_done = 0; exp_id = 0; exp_p = '0;
    r[0] = 1'b0; r[1] = 1'b0; gl[0] = 1'b0; gl[1] = 1'b0;
    ea[0] = '0; ea[1] = '0; eb[0] = '0; eb[1] = '0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      total++;
      if (gnt == 2'b11 || (gnt != 2'b00 && done)) begin
        bad++;
        $display("FAIL rnd.exclusive: got gnt=%b done=%b, required one-hot gnt and no overlap",
                 gnt, done);
      end
      if (gnt != 2'b00) begin
        if (!r[0] && !r[1]) begin
          fail("rnd.spurious_gnt", "grant with no request, required none");
        end else begin
          ew = (r[0] && r[1]) ? ~exp_l : r[1];
          chk("rnd.gnt_sel", gnt, ew ? 2'b10 : 2'b01);
          chk("rnd.gnt_early", (cyc >= next_free), 1);
          chk("rnd.gnt_while_busy", outst, 0);
          outst    = 1'b1;
          exp_id   = ew;
          exp_p    = (2*W)'(ea[ew]) * (2*W)'(eb[ew]);
          exp_done = cyc + 2 + 2 * W + $countones(eb[ew]);
          exp_l    = ew;
          r[ew]    = 1'b0;
        end
      end else if (!outst && cyc >= next_free && (r[0] || r[1])) begin
        fail("rnd.missed_gnt", "no grant, required a grant at this edge");
        next_free = cyc + 1000000;
      end
      if (done) begin
        chk("rnd.done_expected", outst, 1);
        chk("rnd.done_cycle", cyc, exp_done);
        chk("rnd.p", p, exp_p);
        chk("rnd.id", id, exp_id);
        outst = 1'b0;
        next_free = cyc + 2;
      end else if (outst && cyc >= exp_done) begin
        fail("rnd.done_late", "no done at predicted cycle, required done");
        outst = 1'b0;
        next_free = cyc + 2;
      end

      gl[0] = 1'b0; gl[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!r[i] && k < 4000 && $urandom_range(0, 5) == 0) begin
          r[i] = 1'b1; ea[i] = rnd_op(); eb[i] = rnd_op();
          if (i == 0) begin a0 = ea[0]; b0 = eb[0]; end
          else        begin a1 = ea[1]; b1 = eb[1]; end
        end else if (!r[i] && outst && cyc + 2 <= exp_done && $urandom_range(0, 3) == 0) begin
          // Short request glitch with junk operands while busy; must be ignored.
          gl[i] = 1'b1;
          if (i == 0) begin a0 = W'($urandom); b0 = W'($urandom); end
          else        begin a1 = W'($urandom); b1 = W'($urandom); end
        end
      end
      req0 = r[0] | gl[0];
      req1 = r[1] | gl[1];

      if (k >= 4000 && !r[0] && !r[1] && !outst) break;
      if (k == 5999) fail("rnd.drain", "requests still outstanding, required drained");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: W, default 8, operand width in bits (W >= 2).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  requester 0 asks for a multiplication; held high until gnt[0] is seen.
REQ-005 a0, b0  input  W each  requester 0 multiplicand / multiplier, unsigned; stable while req0 high.
REQ-006 req1  input  1  requester 1 request; same rules as req0.
REQ-007 a1, b1  input  W each  requester 1 multiplicand / multiplier, unsigned.
REQ-008 gnt  output  2  one-hot grant, registered; one-cycle pulse in LOAD.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse in DONE; p and id valid.
REQ-011 id  output  1  index of the requester currently or last served.
REQ-012 p  output  2W  product; holds its value until the next LOAD.

Function
REQ-013 One internal shift-add multiplier shared by both requesters: registers A (2W), B (W), P (2W), iteration counter N (ceil(log2(W+1)) bits), plus a last-served pointer L (1 bit).
REQ-014 FSM states: IDLE, LOAD, CHECK, ADD, SHIFT, DONE.
REQ-015 IDLE: if no request, stay; if any request, latch the selected requester's operands and go to LOAD.
REQ-016 Selection: only one requester active -> grant it; both active -> grant the one not equal to L; L updates to the granted index on the IDLE->LOAD edge.
REQ-017 On the IDLE->LOAD edge: A = zero-extended a_sel, B = b_sel, P = 0, N = W, id = selected index.
REQ-018 LOAD: gnt[id] = 1 for exactly this cycle; next state CHECK.
REQ-019 CHECK: N == 0 -> DONE; else B[0] == 1 -> ADD; else SHIFT.
REQ-020 ADD: P = P + A (2W-bit, no overflow possible); next state SHIFT.
REQ-021 SHIFT: A = A << 1, B = B >> 1 (zero fill), N = N - 1; next state CHECK.
REQ-022 DONE: p = P, done = 1 for one cycle; next state IDLE unconditionally.
REQ-023 Latency from LOAD cycle t to DONE cycle = t + 2 + 2W + popcount(b); the iteration count is always W, with no early exit on B == 0.
REQ-024 Requests are sampled only in IDLE; req changes and operand changes in other states are ignored.
REQ-025 Minimum spacing: a request pending during DONE is granted on the edge leaving the following IDLE cycle (LOAD at DONE + 2).
REQ-026 The granted requester must drop req in the cycle after gnt; a req still high when the block returns to IDLE is treated as a new request.
REQ-027 b = 0 or a = 0 -> p = 0 after full W iterations; a = b = 2^W-1 -> p = (2^W-1)^2.
REQ-028 gnt, done mutually exclusive in time; gnt never has both bits set.

Reset
REQ-029 rst high at any time, including mid-operation: state = IDLE, gnt = 0, busy = 0, done = 0, id = 0, p = 0, A = B = P = N = 0, L = 1 (so req0 wins the first tie).
REQ-030 An operation interrupted by reset is discarded; no done pulse, no partial p.
REQ-031 After rst falls, the first rising edge with a request present performs IDLE->LOAD.

Verification
REQ-032 W=8, rst, then req0 with a0=3, b0=5 -> gnt=01 in LOAD at cycle t, done at t+20, p=15, id=0.
REQ-033 W=8, req0 and req1 raised in the same cycle after reset (a0=2,b0=2; a1=7,b1=9) -> req0 served first (p=4, id=0), req1 is granted at DONE+2 (p=63, id=1).
REQ-034 W=8, both requesters held high continuously for 4 operations -> grants alternate 0,1,0,1; each done matches its operands.
REQ-035 W=8, a=255, b=255 -> p=65025 at t+26; a=200, b=0 -> p=0 at t+18.
REQ-036 W=8, rst pulsed during an ADD state -> all outputs 0 immediately (asynchronously), busy=0, no done pulse; the next req0 is granted and computes correctly.
REQ-037 W=8, req1 toggled and operands changed while busy -> no effect on the in-flight product; a request pending at DONE is granted at DONE+2.
